// File: rtl/btn_pkg.sv
// Shared types for the button conditioning path: debounce FSM state encoding
// and the stability-counter width helper.
package btn_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_e;

  // Bits needed to hold 0..max_count inclusive; never less than one bit.
  function automatic int cnt_width(input int max_count);
    return (max_count < 2) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Generic N-stage, WIDTH-bit synchronizer with a parameterized reset value,
// shared by every asynchronous board input.
module sync_ff #(
  parameter int               STAGES    = 2,
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain [STAGES];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) chain[i] <= RESET_VAL;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/btn_debounce.sv
// User-button conditioner: synchronizer, debounce FSM, level plus press/release
// pulses. Define BTN_DEBOUNCE_LONGPRESS_EN to enable the long-press pulse.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter bit BTN_ACTIVE_LOW  = 1'b1,
  parameter int LONG_CYCLES     = 12500000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_i,
  output logic       level_o,
  output logic       press_o,
  output logic       release_o,
  output logic       long_o,
  output btn_state_e dbg_state
);

`ifdef BTN_DEBOUNCE_LONGPRESS_EN
  localparam int  CNT_MAX   = LONG_CYCLES;
  localparam bit  PARAMS_OK = (SYNC_STAGES >= 2) && (DEBOUNCE_CYCLES >= 2) &&
                              (LONG_CYCLES > DEBOUNCE_CYCLES);
`else
  localparam int  CNT_MAX   = DEBOUNCE_CYCLES;
  localparam bit  PARAMS_OK = (SYNC_STAGES >= 2) && (DEBOUNCE_CYCLES >= 2);
`endif
  localparam int            CW       = cnt_width(CNT_MAX);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  if (!PARAMS_OK) begin : g_bad_params
    $error("btn_debounce: bad parameters SYNC_STAGES=%0d DEBOUNCE_CYCLES=%0d LONG_CYCLES=%0d",
           SYNC_STAGES, DEBOUNCE_CYCLES, LONG_CYCLES);
  end

  logic       btn_sync;
  logic       s;
  btn_state_e state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic       press_nxt, release_nxt;

  // Flops reset to the idle pad level so leaving reset never looks like a press.
  sync_ff #(
    .STAGES   (SYNC_STAGES),
    .WIDTH    (1),
    .RESET_VAL(BTN_ACTIVE_LOW ? 1'b1 : 1'b0)
  ) u_sync (
    .clock(clock),
    .reset(reset),
    .d    (btn_i),
    .q    (btn_sync)
  );

  assign s = BTN_ACTIVE_LOW ? ~btn_sync : btn_sync;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    case (state)
      RELEASED: begin
        if (s) begin
          state_nxt = PRESS_WAIT;
          cnt_nxt   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_nxt = RELEASED;
          cnt_nxt   = '0;
        end else if (cnt == DEB_LAST) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
          press_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      PRESSED: begin
        if (!s) begin
          state_nxt = RELEASE_WAIT;
          cnt_nxt   = '0;
        end
`ifdef BTN_DEBOUNCE_LONGPRESS_EN
        else if (cnt != '1) begin
          cnt_nxt = cnt + 1'b1;
        end
`endif
      end
      RELEASE_WAIT: begin
        // Re-entry to PRESSED is silent and restarts the hold timing.
        if (s) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
        end else if (cnt == DEB_LAST) begin
          state_nxt   = RELEASED;
          cnt_nxt     = '0;
          release_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = RELEASED;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= RELEASED;
      cnt       <= '0;
      level_o   <= 1'b0;
      press_o   <= 1'b0;
      release_o <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      level_o   <= (state_nxt == PRESSED) || (state_nxt == RELEASE_WAIT);
      press_o   <= press_nxt;
      release_o <= release_nxt;
    end
  end

`ifdef BTN_DEBOUNCE_LONGPRESS_EN
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);

  logic long_nxt;
  logic long_done;

  // long_done blocks a second pulse until the button is fully released.
  assign long_nxt = (state_nxt == PRESSED) && (state == PRESSED) &&
                    (cnt_nxt == LONG_LAST) && !long_done;

  always_ff @(posedge clock) begin
    if (reset) begin
      long_o    <= 1'b0;
      long_done <= 1'b0;
    end else begin
      long_o <= long_nxt;
      if (state_nxt == RELEASED) long_done <= 1'b0;
      else if (long_nxt)         long_done <= 1'b1;
    end
  end
`else
  assign long_o = 1'b0;
`endif

  assign dbg_state = state;

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce: a scoreboard queue of expected pulses
// {long,release,press,cycle} checked by a negedge monitor, plus direct level checks.
module tb_btn_debounce;
  import btn_pkg::*;

  localparam int W = 32;

  logic       clock   = 1'b0;
  logic       reset   = 1'b1;
  logic       btn_i   = 1'b1;
  logic       level_o, press_o, release_o, long_o;
  btn_state_e dbg_state;

  int         cyc    = 0;
  int         checks = 0;
  int         errors = 0;
  bit         done   = 1'b0;
  logic [W-1:0] exp_q[$];

  btn_debounce #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(8),
    .BTN_ACTIVE_LOW (1'b1),
    .LONG_CYCLES    (32)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .btn_i    (btn_i),
    .level_o  (level_o),
    .press_o  (press_o),
    .release_o(release_o),
    .long_o   (long_o),
    .dbg_state(dbg_state)
  );

  // Clock and cycle counter: cyc == n between posedge n and posedge n+1.
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Driver tasks. A value driven "at cycle n" is first sampled by posedge n.
  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic drive_btn(input int n, input logic v);
    wait_cyc(n - 1);
    btn_i = v;
  endtask

  task automatic drive_reset(input int n, input logic v);
    wait_cyc(n - 1);
    reset = v;
  endtask

  // kind bits: {long, release, press}
  task automatic expect_pulse(input logic [2:0] kind, input int n);
    exp_q.push_back({kind, 29'(n)});
  endtask

  task automatic check_out(input int n, input logic [3:0] want, input string name);
    wait_cyc(n);
    checks++;
    if ({level_o, press_o, release_o, long_o} !== want) begin
      errors++;
      $display("FAIL %s cycle %0d: {level,press,release,long}=%b expected %b",
               name, n, {level_o, press_o, release_o, long_o}, want);
    end
  endtask

  task automatic check_state(input int n, input btn_state_e want, input string name);
    wait_cyc(n);
    checks++;
    if (dbg_state !== want) begin
      errors++;
      $display("FAIL %s cycle %0d: state=%0d expected %0d", name, n, dbg_state, want);
    end
  endtask

  // Scoreboard monitor: every pulse must match the head of the expected queue.
  always @(negedge clock) begin
    logic [2:0]   kind;
    logic [W-1:0] got;
    logic [W-1:0] want;
    if (!done && (press_o || release_o || long_o)) begin
      kind = {long_o, release_o, press_o};
      got  = {kind, 29'(cyc)};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pulse_unexpected: kind(long,release,press)=%b at cycle %0d, none expected",
                 kind, cyc);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          errors++;
          $display("FAIL pulse_match: kind=%b cycle=%0d, expected kind=%b cycle=%0d",
                   got[31:29], got[28:0], want[31:29], want[28:0]);
        end
      end
    end
  end

  initial begin
    // Reset state
    check_out(2, 4'b0000, "reset_state");
    drive_reset(3, 1'b0);

    // Clean press at 10 -> press at 20
    expect_pulse(3'b001, 20);
    drive_btn(10, 1'b0);
    check_out(19, 4'b0000, "press_not_early");
    check_out(20, 4'b1100, "press_edge");
    check_out(21, 4'b1000, "press_one_cycle");

    // Release at 40 -> release at 50
    expect_pulse(3'b010, 50);
    drive_btn(40, 1'b1);
    check_out(45, 4'b1000, "release_wait_level");
    check_out(49, 4'b1000, "release_not_early");
    check_out(50, 4'b0010, "release_edge");
    check_out(51, 4'b0000, "release_one_cycle");

    // Glitch of 7 cycles is one short of acceptance
    drive_btn(60, 1'b0);
    drive_btn(67, 1'b1);
    check_state(65, PRESS_WAIT, "glitch_wait");
    check_state(70, RELEASED, "glitch_rejected");
    check_out(75, 4'b0000, "glitch_outputs");

    // Bounce every 3 cycles, then stable low from 114 -> press at 124
    for (int k = 0; k < 8; k++) drive_btn(90 + 3 * k, (k % 2 == 1) ? 1'b1 : 1'b0);
    expect_pulse(3'b001, 124);
`ifdef BTN_DEBOUNCE_LONGPRESS_EN
    expect_pulse(3'b100, 155);
`endif
    drive_btn(114, 1'b0);
    check_out(123, 4'b0000, "bounce_not_early");
    check_out(124, 4'b1100, "bounce_press");
    expect_pulse(3'b010, 180);
    drive_btn(170, 1'b1);
    check_out(180, 4'b0010, "bounce_release");

    // Short release bounce returns to PRESSED silently; long timing restarts
    expect_pulse(3'b001, 210);
    drive_btn(200, 1'b0);
    check_out(210, 4'b1100, "repress_edge");
    drive_btn(220, 1'b1);
    check_state(223, RELEASE_WAIT, "rebounce_wait");
    check_out(223, 4'b1000, "rebounce_level");
    drive_btn(224, 1'b0);
    check_state(230, PRESSED, "rebounce_back");
`ifdef BTN_DEBOUNCE_LONGPRESS_EN
    expect_pulse(3'b100, 257);
`endif
    check_out(241, 4'b1000, "long_restarted");
    expect_pulse(3'b010, 280);
    drive_btn(270, 1'b1);
    check_out(280, 4'b0010, "rebounce_release");

    // Reset mid-press: no release, press again after reset with button held
    expect_pulse(3'b001, 310);
    drive_btn(300, 1'b0);
    check_out(310, 4'b1100, "pre_reset_press");
    drive_reset(320, 1'b1);
    check_out(321, 4'b0000, "reset_mid_press");
    check_state(321, RELEASED, "reset_state_mid");
    drive_reset(330, 1'b0);
    expect_pulse(3'b001, 340);
    check_out(339, 4'b0000, "post_reset_not_early");
    check_out(340, 4'b1100, "post_reset_press");
    expect_pulse(3'b010, 370);
    drive_btn(360, 1'b1);
    check_out(370, 4'b0010, "post_reset_release");

    wait_cyc(400);
    done = 1'b1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pulses_missing: %0d expected pulses never seen, 0 required", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
